// File: rtl/maze_stream_tx.sv
// rtl/maze_stream_tx.sv - host-side maze image transmitter and path response monitor
// Serialises an NxN maze row-major on in_valid/maze, then collects and checks the solver's answer.
module maze_stream_tx #(
  parameter int N       = 15,
  parameter int TIMEOUT = 3000,
  parameter int LEN_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_row,
  input  logic [N-1:0]     cfg_data,
  input  logic             start,
  output logic             busy,
  output logic             in_valid,
  output logic             maze,
  input  logic             out_valid,
  input  logic             maze_not_valid,
  input  logic [3:0]       out_x,
  input  logic [3:0]       out_y,
  output logic             done,
  output logic             result_invalid,
  output logic             timeout_err,
  output logic             step_err,
  output logic             proto_err,
  output logic [LEN_W-1:0] path_len,
  output logic [3:0]       first_x,
  output logic [3:0]       first_y,
  output logic [3:0]       last_x,
  output logic [3:0]       last_y
);

  localparam int CNT_W = $clog2(N * N + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CELLS   = CNT_W'(N * N);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_PATH, S_DONE} state_t;

  state_t           r_state;
  logic [N-1:0]     r_mem [N];
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_x, r_y;
  logic [TO_W-1:0]  r_wait;
  logic             r_busy, r_in_valid, r_maze, r_done;
  logic             r_inv, r_to, r_step, r_proto;
  logic [LEN_W-1:0] r_len;
  logic [3:0]       r_fx, r_fy, r_lx, r_ly;

  logic              w_row_ok;
  logic              w_cell0;
  logic signed [4:0] w_dx, w_dy;
  logic [4:0]        w_adx, w_ady;
  logic [5:0]        w_dist;

  assign w_row_ok = (cfg_row < 4'(N));
  // A row-0 write in the start cycle must reach the first transmitted cell.
  assign w_cell0  = (cfg_we && cfg_row == 4'd0) ? cfg_data[0] : r_mem[0][0];

  assign w_dx   = $signed({1'b0, out_x}) - $signed({1'b0, r_lx});
  assign w_dy   = $signed({1'b0, out_y}) - $signed({1'b0, r_ly});
  assign w_adx  = w_dx[4] ? $unsigned(-w_dx) : $unsigned(w_dx);
  assign w_ady  = w_dy[4] ? $unsigned(-w_dy) : $unsigned(w_dy);
  assign w_dist = {1'b0, w_adx} + {1'b0, w_ady};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      for (int i = 0; i < N; i++) r_mem[i] <= '0;
      r_cnt      <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_wait     <= '0;
      r_busy     <= 1'b0;
      r_in_valid <= 1'b0;
      r_maze     <= 1'b0;
      r_done     <= 1'b0;
      r_inv      <= 1'b0;
      r_to       <= 1'b0;
      r_step     <= 1'b0;
      r_proto    <= 1'b0;
      r_len      <= '0;
      r_fx       <= '0;
      r_fy       <= '0;
      r_lx       <= '0;
      r_ly       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          r_busy <= 1'b0;
          if (cfg_we && w_row_ok) r_mem[cfg_row] <= cfg_data;
          if (start) begin
            r_state    <= S_SEND;
            r_busy     <= 1'b1;
            r_in_valid <= 1'b1;
            r_maze     <= w_cell0;
            r_cnt      <= CNT_W'(1);
            r_x        <= 4'd1;
            r_y        <= 4'd0;
            r_wait     <= '0;
            r_inv      <= 1'b0;
            r_to       <= 1'b0;
            r_step     <= 1'b0;
            r_proto    <= 1'b0;
            r_len      <= '0;
            r_fx       <= '0;
            r_fy       <= '0;
            r_lx       <= '0;
            r_ly       <= '0;
          end
        end
        S_SEND: begin
          if (out_valid || maze_not_valid) r_proto <= 1'b1;
          if (r_cnt == CELLS) begin
            r_in_valid <= 1'b0;
            r_state    <= S_WAIT;
          end else begin
            r_maze <= r_mem[r_y][r_x];
            r_cnt  <= r_cnt + 1'b1;
            if (r_x == 4'(N - 1)) begin
              r_x <= '0;
              r_y <= r_y + 1'b1;
            end else begin
              r_x <= r_x + 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (maze_not_valid) begin
            r_inv   <= 1'b1;
            r_state <= S_DONE;
          end else if (out_valid) begin
            r_fx    <= out_x;
            r_fy    <= out_y;
            r_lx    <= out_x;
            r_ly    <= out_y;
            r_len   <= LEN_W'(1);
            r_state <= S_PATH;
          end else if (r_wait == TO_LAST) begin
            r_to    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        S_PATH: begin
          if (out_valid) begin
            if (r_len != '1) r_len <= r_len + 1'b1;
            if (w_dist != 6'd1) r_step <= 1'b1;
            r_lx <= out_x;
            r_ly <= out_y;
          end else begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy           = r_busy;
  assign in_valid       = r_in_valid;
  assign maze           = r_maze;
  assign done           = r_done;
  assign result_invalid = r_inv;
  assign timeout_err    = r_to;
  assign step_err       = r_step;
  assign proto_err      = r_proto;
  assign path_len       = r_len;
  assign first_x        = r_fx;
  assign first_y        = r_fy;
  assign last_x         = r_lx;
  assign last_y         = r_ly;

endmodule

// File: tb/tb_maze_stream_tx.sv
// tb/tb_maze_stream_tx.sv - self-checking bench for maze_stream_tx
// Scenario table plus hand sequences for timeout, mid-frame reset and start-cycle writes.
module tb_maze_stream_tx;
  localparam int N = 15;
  localparam int TIMEOUT = 3000;
  localparam int LEN_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_we = 1'b0;
  logic [3:0] cfg_row = '0;
  logic [N-1:0] cfg_data = '0;
  logic start = 1'b0;
  logic out_valid = 1'b0;
  logic maze_not_valid = 1'b0;
  logic [3:0] out_x = '0;
  logic [3:0] out_y = '0;
  logic busy, in_valid, maze, done, result_invalid, timeout_err, step_err, proto_err;
  logic [LEN_W-1:0] path_len;
  logic [3:0] first_x, first_y, last_x, last_y;

  maze_stream_tx #(.N(N), .TIMEOUT(TIMEOUT), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_row(cfg_row), .cfg_data(cfg_data),
    .start(start), .busy(busy), .in_valid(in_valid), .maze(maze),
    .out_valid(out_valid), .maze_not_valid(maze_not_valid), .out_x(out_x), .out_y(out_y),
    .done(done), .result_invalid(result_invalid), .timeout_err(timeout_err),
    .step_err(step_err), .proto_err(proto_err), .path_len(path_len),
    .first_x(first_x), .first_y(first_y), .last_x(last_x), .last_y(last_y)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] fill;
    int           hot_row;
    logic [N-1:0] hot_data;
    int           resp;     // 0 L-path, 1 not-valid, 2 gapped path, 3 long path
    bit           inject;
    int           exp_len;
    bit           exp_step;
    bit           exp_inv;
    bit           exp_proto;
    int           fx, fy, lx, ly;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;
  int n_cells = 0;
  logic [N-1:0] m_mem [N];
  logic exp_q[$];
  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Every cycle advances through here so the cell scoreboard sees each in_valid beat once.
  task automatic tick();
    logic b;
    @(negedge clk);
    if (in_valid) begin
      n_cells++;
      if (exp_q.size() == 0) chk("frame_overrun", n_cells, N * N);
      else begin
        b = exp_q.pop_front();
        chk($sformatf("cell%0d", n_cells - 1), maze, b);
      end
    end
  endtask

  task automatic wr_row(input int r, input logic [N-1:0] d);
    cfg_we = 1'b1; cfg_row = 4'(r); cfg_data = d;
    if (r < N) m_mem[r] = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic do_start(input bit with_we, input int r, input logic [N-1:0] d);
    if (with_we) begin
      cfg_we = 1'b1; cfg_row = 4'(r); cfg_data = d;
      if (r < N) m_mem[r] = d;
    end
    for (int y = 0; y < N; y++)
      for (int x = 0; x < N; x++) exp_q.push_back(m_mem[y][x]);
    n_cells = 0;
    start = 1'b1;
    tick();
    start = 1'b0; cfg_we = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic finish_send(input bit inject);
    int g = 0;
    while (in_valid && g < 300) begin
      out_valid = inject && (n_cells == 50);
      tick();
      g++;
    end
    out_valid = 1'b0;
    chk("frame_cells", n_cells, N * N);
    chk("frame_queue_left", exp_q.size(), 0);
  endtask

  task automatic wait_done();
    int g = 0;
    while (!done && g < 4000) begin tick(); g++; end
    chk("done_seen", done, 1);
    chk("busy_at_done", busy, 1);
  endtask

  task automatic after_done();
    tick();
    chk("done_one_cycle", done, 0);
    chk("busy_after_done", busy, 0);
  endtask

  task automatic drive_pt(input int x, input int y);
    out_valid = 1'b1; out_x = 4'(x); out_y = 4'(y);
    tick();
  endtask

  task automatic respond(input int kind);
    case (kind)
      0: for (int i = 0; i < 29; i++) drive_pt(i <= 14 ? i : 14, i <= 14 ? 0 : i - 14);
      1: begin
        for (int i = 0; i < 9; i++) tick();
        maze_not_valid = 1'b1;
        tick();
        maze_not_valid = 1'b0;
        chk("inv_before_done", result_invalid, 1);
        chk("done_lags_inv", done, 0);
      end
      2: begin drive_pt(0, 0); drive_pt(1, 0); drive_pt(3, 0); end
      default: for (int i = 0; i < 300; i++) drive_pt(i % 2, 0);
    endcase
    out_valid = 1'b0;
  endtask

  initial begin
    int n;
    vecs[0] = '{15'h7FFF, -1, 15'h0000, 0, 1'b0, 29, 1'b0, 1'b0, 1'b0, 0, 0, 14, 14};
    vecs[1] = '{15'h0000, 3, 15'h0001, 1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0};
    vecs[2] = '{15'h5555, 7, 15'h2AAA, 2, 1'b0, 3, 1'b1, 1'b0, 1'b0, 0, 0, 3, 0};
    vecs[3] = '{15'h0000, 14, 15'h4000, 0, 1'b1, 29, 1'b0, 1'b0, 1'b1, 0, 0, 14, 14};
    vecs[4] = '{15'h1234, 15, 15'h7FFF, 3, 1'b0, 255, 1'b0, 1'b0, 1'b0, 0, 0, 1, 0};
    for (int i = 0; i < N; i++) m_mem[i] = '0;

    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_in_valid", in_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_path_len", path_len, 0);
    chk("rst_errs", {result_invalid, timeout_err, step_err, proto_err}, 0);

    foreach (vecs[k]) begin
      for (int r = 0; r < N; r++) wr_row(r, (r == vecs[k].hot_row) ? vecs[k].hot_data : vecs[k].fill);
      if (vecs[k].hot_row >= N) wr_row(vecs[k].hot_row, vecs[k].hot_data);
      do_start(1'b0, 0, '0);
      finish_send(vecs[k].inject);
      respond(vecs[k].resp);
      wait_done();
      chk($sformatf("v%0d_path_len", k), path_len, vecs[k].exp_len);
      chk($sformatf("v%0d_step_err", k), step_err, vecs[k].exp_step);
      chk($sformatf("v%0d_result_invalid", k), result_invalid, vecs[k].exp_inv);
      chk($sformatf("v%0d_proto_err", k), proto_err, vecs[k].exp_proto);
      chk($sformatf("v%0d_timeout_err", k), timeout_err, 0);
      chk($sformatf("v%0d_first", k), {first_x, first_y}, {4'(vecs[k].fx), 4'(vecs[k].fy)});
      chk($sformatf("v%0d_last", k), {last_x, last_y}, {4'(vecs[k].lx), 4'(vecs[k].ly)});
      after_done();
    end

    // Reset in the middle of a frame, then confirm memory was cleared and a full frame follows.
    for (int r = 0; r < N; r++) wr_row(r, 15'h7FFF);
    do_start(1'b0, 0, '0);
    n = 0;
    while (n_cells < 100 && n < 200) begin tick(); n++; end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < N; i++) m_mem[i] = '0;
    chk("rst_mid_in_valid", in_valid, 0);
    chk("rst_mid_busy", busy, 0);
    do_start(1'b0, 0, '0);
    finish_send(1'b0);
    respond(1);
    wait_done();
    after_done();

    // Reloaded frame with no answer must time out after exactly TIMEOUT idle cycles.
    for (int r = 0; r < N; r++) wr_row(r, 15'h7FFF);
    do_start(1'b0, 0, '0);
    finish_send(1'b0);
    n = 1;
    while (!timeout_err && n < TIMEOUT + 100) begin
      tick();
      if (!timeout_err) n++;
    end
    chk("timeout_cycles", n, TIMEOUT);
    chk("timeout_err", timeout_err, 1);
    wait_done();
    chk("timeout_path_len", path_len, 0);
    after_done();

    // Row write in the start cycle is transmitted; not-valid beats a simultaneous out_valid.
    for (int r = 0; r < N; r++) wr_row(r, 15'h0000);
    do_start(1'b1, 0, 15'h0001);
    finish_send(1'b0);
    maze_not_valid = 1'b1; out_valid = 1'b1; out_x = 4'd2; out_y = 4'd2;
    tick();
    maze_not_valid = 1'b0; out_valid = 1'b0;
    wait_done();
    chk("prio_result_invalid", result_invalid, 1);
    chk("prio_path_len", path_len, 0);
    after_done();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
